// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
package riscv_mem_pkg;

    localparam int         DEF_XLEN = 32;
    localparam logic [3:0] BE_FULL  = 4'hF;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
    typedef enum logic {OWN_IF, OWN_DM}   owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests: DM by default,
// IF when it is alone or when DM has monopolised the port long enough.
module mem_arb_pick (
    input  logic if_req,
    input  logic dm_req,
    input  logic streak_sat,
    output logic grant_if,
    output logic grant_dm
);

    assign grant_dm = dm_req & ~(if_req & streak_sat);
    assign grant_if = if_req & ~grant_dm;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory between the
// IF and MEM pipeline stages, with per-stage stalls and IF starvation guard.
module mem_arbiter #(
    parameter int XLEN          = riscv_mem_pkg::DEF_XLEN,
    parameter int MEM_LAT       = 2,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_stall,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [3:0]      dm_be,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_rvalid,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_stall,
    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);
    import riscv_mem_pkg::*;

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [CW-1:0] LAT_C      = CW'(MEM_LAT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    state_e        state;
    owner_e        owner;
    logic          owner_we;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;

    logic idle, done, streak_sat;
    logic pick_if, pick_dm, issue_if, issue_dm;

    // Reset wins over a same-cycle request and suppresses a pending completion.
    assign idle       = (state == ST_IDLE) & ~rst;
    assign done       = (state == ST_BUSY) & ~rst & (cnt == LAT_C);
    assign streak_sat = (streak == STREAK_MAX);

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .streak_sat (streak_sat),
        .grant_if   (pick_if),
        .grant_dm   (pick_dm)
    );

    assign issue_if = idle & pick_if;
    assign issue_dm = idle & pick_dm;

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue_dm) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (issue_if) begin
            mem_en    = 1'b1;
            mem_be    = BE_FULL;
            mem_addr  = if_addr;
        end
    end

    assign if_rvalid = done & (owner == OWN_IF);
    assign dm_rvalid = done & (owner == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !owner_we) ? mem_rdata : '0;
    assign if_stall  = if_req & ~if_rvalid;
    assign dm_stall  = dm_req & ~dm_rvalid;

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= OWN_IF;
            owner_we <= 1'b0;
            cnt      <= '0;
            streak   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_if || issue_dm) begin
                        state    <= ST_BUSY;
                        cnt      <= CW'(1);
                        owner    <= issue_dm ? OWN_DM : OWN_IF;
                        owner_we <= issue_dm & dm_we;
                    end
                    if (issue_if || !if_req)
                        streak <= '0;
                    else if (issue_dm && !streak_sat)
                        streak <= streak + SW'(1);
                end
                ST_BUSY: begin
                    if (done) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written streak and
// MEM_LAT=1 sequences, and randomized traffic against a transaction model.
module tb_mem_arbiter;

    localparam int LAT  = 2;
    localparam int MAXS = 2;

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        irv;
        logic [31:0] ird;
        logic        drv;
        logic [31:0] drd;
        logic        is;
        logic        ds;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT with MEM_LAT=2, MAX_DM_STREAK=2 ----------------
    in_t vin;
    logic        if_rvalid, if_stall, dm_rvalid, dm_stall, mem_en, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    mem_arbiter #(.XLEN(32), .MEM_LAT(LAT), .MAX_DM_STREAK(MAXS)) dut (
        .clk(clk), .rst(vin.rst),
        .if_req(vin.ireq), .if_addr(vin.iaddr),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(vin.dreq), .dm_we(vin.dwe), .dm_be(vin.dbe),
        .dm_addr(vin.daddr), .dm_wdata(vin.dwd),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(vin.mrd)
    );

    // ---------------- DUT with MEM_LAT=1 ----------------
    in_t vin1;
    logic        if_rvalid1, if_stall1, dm_rvalid1, dm_stall1, mem_en1, mem_we1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
    logic [3:0]  mem_be1;

    mem_arbiter #(.XLEN(32), .MEM_LAT(1), .MAX_DM_STREAK(MAXS)) dut1 (
        .clk(clk), .rst(vin1.rst),
        .if_req(vin1.ireq), .if_addr(vin1.iaddr),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1), .if_stall(if_stall1),
        .dm_req(vin1.dreq), .dm_we(vin1.dwe), .dm_be(vin1.dbe),
        .dm_addr(vin1.daddr), .dm_wdata(vin1.dwd),
        .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1), .dm_stall(dm_stall1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(vin1.mrd)
    );

    function automatic out_t cur();
        return {mem_en, mem_we, mem_be, mem_addr, mem_wdata,
                if_rvalid, if_rdata, dm_rvalid, dm_rdata, if_stall, dm_stall};
    endfunction

    function automatic in_t i_(logic r, logic ireq, logic [31:0] iaddr,
                               logic dreq, logic dwe, logic [3:0] dbe,
                               logic [31:0] daddr, logic [31:0] dwd,
                               logic [31:0] mrd);
        return {r, ireq, iaddr, dreq, dwe, dbe, daddr, dwd, mrd};
    endfunction

    function automatic out_t o_(logic en, logic we, logic [3:0] be,
                                logic [31:0] addr, logic [31:0] wdata,
                                logic irv, logic [31:0] ird,
                                logic drv, logic [31:0] drd,
                                logic is, logic ds);
        return {en, we, be, addr, wdata, irv, ird, drv, drd, is, ds};
    endfunction

    function automatic out_t o_st(logic is, logic ds);
        return o_(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, is, ds);
    endfunction

    function automatic vec_t v(string n, in_t i, out_t o);
        vec_t r;
        r.name = n;
        r.i    = i;
        r.o    = o;
        return r;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: one access in flight, identified by the
    // cycle it was issued in; completion is issue cycle + LAT.
    int   m_issue  = -1;
    int   m_owner  = 0;       // 0 = IF, 1 = DM
    bit   m_we     = 0;
    int   m_streak = 0;
    int   m_cyc    = 0;

    function automatic out_t model_out(in_t x, output int grant);
        out_t e = '0;
        grant = -1;
        if (!x.rst) begin
            if (m_issue >= 0) begin
                if (m_cyc == m_issue + LAT) begin
                    if (m_owner == 0) begin
                        e.irv = 1'b1;
                        e.ird = x.mrd;
                    end else begin
                        e.drv = 1'b1;
                        e.drd = m_we ? 32'h0 : x.mrd;
                    end
                end
            end else if (x.ireq || x.dreq) begin
                if (x.dreq && !(x.ireq && m_streak == MAXS)) grant = 1;
                else grant = 0;
                e.en = 1'b1;
                if (grant == 1) begin
                    e.we    = x.dwe;
                    e.be    = x.dbe;
                    e.addr  = x.daddr;
                    e.wdata = x.dwd;
                end else begin
                    e.be    = 4'hF;
                    e.addr  = x.iaddr;
                end
            end
        end
        e.is = x.ireq & ~e.irv;
        e.ds = x.dreq & ~e.drv;
        return e;
    endfunction

    task automatic model_advance(input in_t x, input out_t e, input int grant);
        if (x.rst) begin
            m_issue  = -1;
            m_streak = 0;
        end else if (m_issue >= 0) begin
            if (e.irv || e.drv) m_issue = -1;
        end else begin
            if (grant >= 0) begin
                m_issue = m_cyc;
                m_owner = grant;
                m_we    = (grant == 1) && x.dwe;
            end
            if (grant == 0 || !x.ireq) m_streak = 0;
            else if (grant == 1 && m_streak < MAXS) m_streak++;
        end
        m_cyc++;
    endtask

    vec_t vecs[$];

    initial begin
        vin  = i_(1, 0, 0, 0, 0, 0, 0, 0, 0);
        vin1 = i_(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();
        vin1.rst = 1'b0;

        // Directed vectors, one row per cycle.
        vecs.push_back(v("reset",      i_(1,0,0,0,0,0,0,0,0), o_st(0,0)));
        vecs.push_back(v("f_issue",    i_(0,1,32'h100,0,0,0,0,0,0),
                                       o_(1,0,4'hF,32'h100,0,0,0,0,0,1,0)));
        vecs.push_back(v("f_wait",     i_(0,1,32'h100,0,0,0,0,0,32'h5A5A5A5A), o_st(1,0)));
        vecs.push_back(v("f_done",     i_(0,1,32'h100,0,0,0,0,0,32'hDEADBEEF),
                                       o_(0,0,0,0,0,1,32'hDEADBEEF,0,0,0,0)));
        vecs.push_back(v("f_idle",     i_(0,0,0,0,0,0,0,0,32'h77), o_st(0,0)));
        vecs.push_back(v("b_dm_issue", i_(0,1,32'h104,1,0,4'hF,32'h2000,0,0),
                                       o_(1,0,4'hF,32'h2000,0,0,0,0,0,1,1)));
        vecs.push_back(v("b_dm_wait",  i_(0,1,32'h104,1,0,4'hF,32'h2000,0,0), o_st(1,1)));
        vecs.push_back(v("b_dm_done",  i_(0,1,32'h104,1,0,4'hF,32'h2000,0,32'h11112222),
                                       o_(0,0,0,0,0,0,0,1,32'h11112222,1,0)));
        vecs.push_back(v("b_if_issue", i_(0,1,32'h104,0,0,0,0,0,0),
                                       o_(1,0,4'hF,32'h104,0,0,0,0,0,1,0)));
        vecs.push_back(v("b_if_wait",  i_(0,1,32'h104,0,0,0,0,0,0), o_st(1,0)));
        vecs.push_back(v("b_if_done",  i_(0,1,32'h104,0,0,0,0,0,32'h33334444),
                                       o_(0,0,0,0,0,1,32'h33334444,0,0,0,0)));
        vecs.push_back(v("b_idle",     i_(0,0,0,0,0,0,0,0,0), o_st(0,0)));
        vecs.push_back(v("s_issue",    i_(0,0,0,1,1,4'b0011,32'h2004,32'h1234ABCD,0),
                                       o_(1,1,4'b0011,32'h2004,32'h1234ABCD,0,0,0,0,0,1)));
        vecs.push_back(v("s_wait",     i_(0,0,0,1,1,4'b0011,32'h2004,32'h1234ABCD,32'hFFFFFFFF),
                                       o_st(0,1)));
        vecs.push_back(v("s_done",     i_(0,0,0,1,1,4'b0011,32'h2004,32'h1234ABCD,32'hCAFEF00D),
                                       o_(0,0,0,0,0,0,0,1,0,0,0)));
        vecs.push_back(v("s_idle",     i_(0,0,0,0,0,0,0,0,0), o_st(0,0)));
        vecs.push_back(v("r_issue",    i_(0,1,32'h200,0,0,0,0,0,0),
                                       o_(1,0,4'hF,32'h200,0,0,0,0,0,1,0)));
        vecs.push_back(v("r_rst",      i_(1,1,32'h200,0,0,0,0,0,0), o_st(1,0)));
        vecs.push_back(v("r_discard",  i_(0,0,0,0,0,0,0,0,32'hBAD0BAD0), o_st(0,0)));
        vecs.push_back(v("r_reissue",  i_(0,1,32'h200,0,0,0,0,0,0),
                                       o_(1,0,4'hF,32'h200,0,0,0,0,0,1,0)));
        vecs.push_back(v("r_wait",     i_(0,1,32'h200,0,0,0,0,0,0), o_st(1,0)));
        vecs.push_back(v("r_done",     i_(0,1,32'h200,0,0,0,0,0,32'h0A0B0C0D),
                                       o_(0,0,0,0,0,1,32'h0A0B0C0D,0,0,0,0)));
        vecs.push_back(v("p_rst",      i_(1,1,32'h300,1,0,4'hF,32'h3000,0,0), o_st(1,1)));
        vecs.push_back(v("p_issue",    i_(0,1,32'h300,1,0,4'hF,32'h3000,0,0),
                                       o_(1,0,4'hF,32'h3000,0,0,0,0,0,1,1)));
        vecs.push_back(v("p_drop",     i_(0,0,0,0,0,0,0,0,0), o_st(0,0)));
        vecs.push_back(v("p_done",     i_(0,0,0,0,0,0,0,0,32'h600DF00D),
                                       o_(0,0,0,0,0,0,0,1,32'h600DF00D,0,0)));
        vecs.push_back(v("p_idle",     i_(0,0,0,0,0,0,0,0,0), o_st(0,0)));

        foreach (vecs[k]) begin
            vin = vecs[k].i;
            @(negedge clk);
            check(vecs[k].name, cur(), vecs[k].o);
            next_cycle();
        end

        // Streak guard: both requesters held high, DM re-requests after each ack.
        begin
            int  iss_cyc[$];
            bit  iss_dm[$];
            int  exp_cyc[4] = '{0, 3, 6, 9};
            bit  exp_dm[4]  = '{1, 1, 0, 1};
            bit  drv;
            vin = i_(0, 1, 32'h400, 1, 0, 4'hF, 32'h3000, 0, 0);
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (mem_en) begin
                    iss_cyc.push_back(c);
                    iss_dm.push_back(mem_addr != 32'h400);
                end
                drv = dm_rvalid;
                next_cycle();
                if (drv) vin.daddr = vin.daddr + 32'h4;
            end
            check_val("streak_issue_count", iss_cyc.size(), 4);
            for (int k = 0; k < 4 && k < iss_cyc.size(); k++)
                check_val($sformatf("streak_issue%0d", k),
                          {iss_dm[k], 31'(iss_cyc[k])}, {exp_dm[k], 31'(exp_cyc[k])});
            vin = i_(1, 0, 0, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end

        // MEM_LAT=1: back-to-back fetches, issue every other cycle.
        begin
            logic [5:0] en_mask = '0;
            logic [5:0] rv_mask = '0;
            vin1 = i_(0, 1, 32'h500, 0, 0, 0, 0, 0, 32'h13572468);
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                en_mask[c] = mem_en1;
                rv_mask[c] = if_rvalid1 && (if_rdata1 == 32'h13572468);
                next_cycle();
            end
            check_val("lat1_issue_cycles", 32'(en_mask), 32'(6'b010101));
            check_val("lat1_rvalid_cycles", 32'(rv_mask), 32'(6'b101010));
            vin1 = i_(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Randomized traffic against the transaction model.
        m_issue = -1; m_streak = 0; m_cyc = 0;
        vin = i_(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vin.rst = 1'b1;
        for (int c = 0; c < 600; c++) begin
            out_t e;
            int   g;
            if (c > 0) vin.rst = ($urandom_range(0, 39) == 0);
            vin.mrd = $urandom;
            e = model_out(vin, g);
            @(negedge clk);
            check("rand", cur(), e);
            next_cycle();
            model_advance(vin, e, g);
            if (!vin.ireq || e.irv) begin
                vin.ireq  = ($urandom_range(0, 3) != 0);
                vin.iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!vin.dreq || e.drv) begin
                vin.dreq  = ($urandom_range(0, 3) != 0);
                vin.dwe   = 1'($urandom_range(0, 1));
                vin.dbe   = 4'($urandom_range(1, 15));
                vin.daddr = $urandom;
                vin.dwd   = $urandom;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
